// File: rtl/cpu_control_fsm_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the multi-cycle CPU control unit: word widths,
// state encoding, opcode/opext values, ALU codes, branch condition codes,
// psr flag positions, controlbits field positions and small instruction
// decode helpers used by the FSM.
// Optional feature macro (used by the interface/top): CPU_CTRL_MEMWAIT_EN.
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

  localparam int WIDTH      = 16;
  localparam int REGBITS    = 4;
  localparam int NUM_STATES = 8;
  localparam int STATE_BITS = 3;
  localparam int CTRL_BITS  = 11;
  localparam int PSR_BITS   = 5;

  typedef logic [STATE_BITS-1:0] state_t;

  // State encoding
  localparam state_t S_FETCH  = 3'd0;
  localparam state_t S_DECODE = 3'd1;
  localparam state_t S_EXEC   = 3'd2;
  localparam state_t S_MEM_RD = 3'd3;
  localparam state_t S_MEM_WR = 3'd4;
  localparam state_t S_BRANCH = 3'd5;
  localparam state_t S_PC_INC = 3'd6;
  localparam state_t S_HALT   = 3'd7;

  // Opcodes (instr[15:12])
  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_MEM   = 4'b0100;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_SUBI  = 4'b1001;
  localparam logic [3:0] OP_CMPI  = 4'b1011;
  localparam logic [3:0] OP_BCOND = 4'b1100;
  localparam logic [3:0] OP_MOVI  = 4'b1101;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  // Opcode extensions (instr[7:4])
  localparam logic [3:0] EXT_AND  = 4'b0001;
  localparam logic [3:0] EXT_OR   = 4'b0010;
  localparam logic [3:0] EXT_XOR  = 4'b0011;
  localparam logic [3:0] EXT_ADD  = 4'b0101;
  localparam logic [3:0] EXT_SUB  = 4'b1001;
  localparam logic [3:0] EXT_CMP  = 4'b1011;
  localparam logic [3:0] EXT_MOV  = 4'b1101;
  localparam logic [3:0] EXT_LOAD = 4'b0000;
  localparam logic [3:0] EXT_STOR = 4'b0100;

  // ALU codes
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_CMP = 4'b0101;
  localparam logic [3:0] ALU_MOV = 4'b0110;

  // Branch condition codes (Rdest field of Bcond)
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_GT = 4'b0110;
  localparam logic [3:0] COND_LE = 4'b0111;
  localparam logic [3:0] COND_UC = 4'b1110;

  // psr flag positions
  localparam int PSR_C = 0;
  localparam int PSR_L = 1;
  localparam int PSR_F = 2;
  localparam int PSR_Z = 3;
  localparam int PSR_N = 4;

  // controlbits field positions
  localparam int CB_ALU_LSB = 0;
  localparam int CB_ALU_MSB = 3;
  localparam int CB_ALU_ONE = 4;
  localparam int CB_IMM_SEL = 5;
  localparam int CB_PC_SEL  = 6;
  localparam int CB_WB_MEM  = 7;
  localparam int CB_PC_WR   = 8;
  localparam int CB_REG_WR  = 9;
  localparam int CB_MEM_WE  = 10;

  typedef enum logic [2:0] {
    CLS_EXEC   = 3'd0,
    CLS_LOAD   = 3'd1,
    CLS_STOR   = 3'd2,
    CLS_BRANCH = 3'd3,
    CLS_HALT   = 3'd4,
    CLS_NOP    = 3'd5
  } instr_class_t;

  // Instruction class. R-type with an unlisted opext and memory ops other
  // than LOAD/STOR fall back to NOP so no register or memory is written.
  function automatic instr_class_t classify(input logic [WIDTH-1:0] instr);
    instr_class_t cls;
    cls = CLS_NOP;
    case (instr[15:12])
      OP_RTYPE: begin
        case (instr[7:4])
          EXT_ADD, EXT_SUB, EXT_AND, EXT_OR, EXT_XOR, EXT_CMP, EXT_MOV: cls = CLS_EXEC;
          default: cls = CLS_NOP;
        endcase
      end
      OP_ADDI, OP_SUBI, OP_CMPI, OP_MOVI: cls = CLS_EXEC;
      OP_MEM: begin
        case (instr[7:4])
          EXT_LOAD: cls = CLS_LOAD;
          EXT_STOR: cls = CLS_STOR;
          default:  cls = CLS_NOP;
        endcase
      end
      OP_BCOND: cls = CLS_BRANCH;
      OP_HALT:  cls = CLS_HALT;
      default:  cls = CLS_NOP;
    endcase
    return cls;
  endfunction

  // ALU code for an execute-class instruction.
  function automatic logic [3:0] exec_alucode(input logic [WIDTH-1:0] instr);
    logic [3:0] code;
    code = ALU_ADD;
    case (instr[15:12])
      OP_RTYPE: begin
        case (instr[7:4])
          EXT_ADD: code = ALU_ADD;
          EXT_SUB: code = ALU_SUB;
          EXT_AND: code = ALU_AND;
          EXT_OR:  code = ALU_OR;
          EXT_XOR: code = ALU_XOR;
          EXT_CMP: code = ALU_CMP;
          EXT_MOV: code = ALU_MOV;
          default: code = ALU_ADD;
        endcase
      end
      OP_ADDI: code = ALU_ADD;
      OP_SUBI: code = ALU_SUB;
      OP_CMPI: code = ALU_CMP;
      OP_MOVI: code = ALU_MOV;
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/cpu_control_fsm_if.sv
// ---------------------------------------------------------------------------
// cpu_control_fsm_if
// Bundles the control unit's datapath-facing signals.
//   instr[15:0]       instruction word        (datapath -> control)
//   psr[4:0]          flags C,L,F,Z,N         (datapath -> control)
//   mem_ready         data memory ready       (only with CPU_CTRL_MEMWAIT_EN)
//   controlbits[10:0] datapath control word   (control -> datapath)
//   jump              condition strobe to ALU (control -> datapath)
//   state_out[2:0]    current state, debug    (control -> datapath)
// modport master: control unit side; modport slave: datapath side.
// ---------------------------------------------------------------------------
interface cpu_control_fsm_if;

  logic [cpu_ctrl_pkg::WIDTH-1:0]      instr;
  logic [cpu_ctrl_pkg::PSR_BITS-1:0]   psr;
  logic [cpu_ctrl_pkg::CTRL_BITS-1:0]  controlbits;
  logic                                jump;
  logic [cpu_ctrl_pkg::STATE_BITS-1:0] state_out;

`ifdef CPU_CTRL_MEMWAIT_EN
  logic mem_ready;

  modport master (input instr, psr, mem_ready, output controlbits, jump, state_out);
  modport slave  (output instr, psr, mem_ready, input controlbits, jump, state_out);
`else
  modport master (input instr, psr, output controlbits, jump, state_out);
  modport slave  (output instr, psr, input controlbits, jump, state_out);
`endif

endinterface

// File: rtl/cpu_control_fsm_cond_eval.sv
// ---------------------------------------------------------------------------
// cond_eval
// Combinational branch condition evaluation.
//   cond[3:0]  condition code from the Bcond Rdest field
//   psr[4:0]   datapath flags
//   taken      1 when the condition holds; undefined codes never hold
// ---------------------------------------------------------------------------
module cond_eval
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0]          cond,
  input  logic [PSR_BITS-1:0] psr,
  output logic                taken
);

  // L and F do not take part in any defined condition.
  logic unused_psr_s;
  assign unused_psr_s = ^{psr[PSR_L], psr[PSR_F]};

  // Condition code to taken decode
  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_EQ: taken = psr[PSR_Z];
      COND_NE: taken = ~psr[PSR_Z];
      COND_CS: taken = psr[PSR_C];
      COND_CC: taken = ~psr[PSR_C];
      COND_GT: taken = psr[PSR_N];
      COND_LE: taken = ~psr[PSR_N];
      COND_UC: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// ---------------------------------------------------------------------------
// cpu_control_fsm
// Multi-cycle control unit for the 16-bit CPU datapath. Sequences
// fetch / decode / execute / memory / branch / PC-increment per instruction.
// Outputs are decoded from the registered state (plus instr, psr, and
// mem_ready when enabled), so an asynchronous reset clears them at once.
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-low reset
//   bus    cpu_control_fsm_if.master (instr, psr, controlbits, jump,
//          state_out, and mem_ready when CPU_CTRL_MEMWAIT_EN is defined)
// Optional feature macro: CPU_CTRL_MEMWAIT_EN -- memory states wait for
// mem_ready; regwrite (LOAD) / mem_we (STOR) assert only in the ready cycle.
// ---------------------------------------------------------------------------
module cpu_control_fsm
  import cpu_ctrl_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  cpu_control_fsm_if.master bus
);

  state_t               state_r;
  state_t               next_state_s;
  logic                 taken_s;
  logic                 mem_ready_s;
  logic [CTRL_BITS-1:0] ctrl_s;
  logic                 jump_s;
  instr_class_t         cls_s;

`ifdef CPU_CTRL_MEMWAIT_EN
  assign mem_ready_s = bus.mem_ready;
`else
  // Memory always answers in one cycle.
  assign mem_ready_s = 1'b1;
`endif

  assign cls_s = classify(bus.instr);

  cond_eval u_cond_eval (
    .cond  (bus.instr[11:8]),
    .psr   (bus.psr),
    .taken (taken_s)
  );

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = S_FETCH;
    case (state_r)
      S_FETCH: next_state_s = S_DECODE;
      S_DECODE: begin
        case (cls_s)
          CLS_EXEC:   next_state_s = S_EXEC;
          CLS_LOAD:   next_state_s = S_MEM_RD;
          CLS_STOR:   next_state_s = S_MEM_WR;
          CLS_BRANCH: next_state_s = S_BRANCH;
          CLS_HALT:   next_state_s = S_HALT;
          default:    next_state_s = S_PC_INC;
        endcase
      end
      S_EXEC: next_state_s = S_PC_INC;
      S_MEM_RD, S_MEM_WR: begin
        if (mem_ready_s) begin
          next_state_s = S_PC_INC;
        end else begin
          next_state_s = state_r;
        end
      end
      // A taken branch loads the target and skips the PC increment.
      S_BRANCH: begin
        if (taken_s) begin
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_PC_INC;
        end
      end
      S_PC_INC: next_state_s = S_FETCH;
      S_HALT:   next_state_s = S_HALT;
      default:  next_state_s = S_FETCH;
    endcase
  end

  // Output decode
  always_comb begin
    ctrl_s = 11'h000;
    jump_s = 1'b0;
    case (state_r)
      S_EXEC: begin
        ctrl_s[CB_ALU_MSB:CB_ALU_LSB] = exec_alucode(bus.instr);
        ctrl_s[CB_IMM_SEL] = (bus.instr[15:12] != OP_RTYPE);
        // Compares only update flags.
        ctrl_s[CB_REG_WR]  = (exec_alucode(bus.instr) != ALU_CMP);
      end
      S_MEM_RD: begin
        ctrl_s[CB_WB_MEM] = 1'b1;
        ctrl_s[CB_REG_WR] = mem_ready_s;
      end
      S_MEM_WR: begin
        ctrl_s[CB_MEM_WE] = mem_ready_s;
      end
      // Target = pc + sign-extended imm8 through the ALU.
      S_BRANCH: begin
        jump_s = 1'b1;
        ctrl_s[CB_ALU_MSB:CB_ALU_LSB] = ALU_ADD;
        ctrl_s[CB_PC_SEL]  = 1'b1;
        ctrl_s[CB_IMM_SEL] = 1'b1;
        ctrl_s[CB_PC_WR]   = taken_s;
      end
      // pc <- pc + 1 using the ALU's constant-one A input.
      S_PC_INC: begin
        ctrl_s[CB_ALU_MSB:CB_ALU_LSB] = ALU_ADD;
        ctrl_s[CB_ALU_ONE] = 1'b1;
        ctrl_s[CB_PC_SEL]  = 1'b1;
        ctrl_s[CB_PC_WR]   = 1'b1;
      end
      S_FETCH, S_DECODE, S_HALT: begin
        ctrl_s = 11'h000;
      end
      default: begin
        ctrl_s = 11'h000;
      end
    endcase
  end

  assign bus.controlbits = ctrl_s;
  assign bus.jump        = jump_s;
  assign bus.state_out   = state_r;

endmodule
